// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// master: requester/memory side; slave: arbiter side.
interface data_mem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic          p0_rvalid;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic          p1_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rvalid,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rvalid,
        input  rdata,
        input  mem_we, mem_re, mem_addr, mem_wd,
        output mem_rd
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rvalid,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rvalid,
        output rdata,
        output mem_we, mem_re, mem_addr, mem_wd,
        input  mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port registered-read data memory; port 0 has priority.
// Define MEM_ARB_WAIT_GUARD_EN to force a port-1 grant after MAX_WAIT consecutive denials.
module data_mem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
`ifdef MEM_ARB_WAIT_GUARD_EN
    ,
    parameter int unsigned MAX_WAIT = 4
`endif
) (
    input logic               CLK,
    input logic               RST,
    data_mem_arbiter_if.slave bus
);
    logic grant0;
    logic grant1;
    logic force1;
    logic rvalid0_q;
    logic rvalid1_q;

`ifdef MEM_ARB_WAIT_GUARD_EN
    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    assign force1 = bus.p1_req && (wait_cnt_q == WaitMax);

    // Counts consecutive denied cycles of a live port-1 request; any grant or idle cycle clears it.
    always_comb begin
        wait_cnt_d = 4'd0;
        if (bus.p1_req && !grant1) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? WaitMax : wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force1 = 1'b0;
`endif

    // Grants are suppressed while reset is held so nothing reaches the memory.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (RST) begin
            if (bus.p1_req && (!bus.p0_req || force1)) begin
                grant1 = 1'b1;
            end else if (bus.p0_req) begin
                grant0 = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        if (grant0) begin
            bus.mem_addr = bus.p0_addr;
            bus.mem_we   = bus.p0_we;
            bus.mem_re   = !bus.p0_we;
            bus.mem_wd   = bus.p0_we ? bus.p0_wdata : '0;
        end else if (grant1) begin
            bus.mem_addr = bus.p1_addr;
            bus.mem_we   = bus.p1_we;
            bus.mem_re   = !bus.p1_we;
            bus.mem_wd   = bus.p1_we ? bus.p1_wdata : '0;
        end
    end

    // One owner bit per port, aligned with the memory's registered read port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= grant0 && !bus.p0_we;
            rvalid1_q <= grant1 && !bus.p1_we;
        end
    end

    assign bus.p0_ack    = grant0;
    assign bus.p1_ack    = grant1;
    assign bus.p0_rvalid = rvalid0_q;
    assign bus.p1_rvalid = rvalid1_q;
    assign bus.rdata     = bus.mem_rd;
endmodule
